dot_accumulator: RTL

- Downstream consumer of the 4x4 carry-save multiplier's 8-bit product.
- Accumulates a fixed-length group of N_TERMS unsigned products into a wider sum (a dot-product / MAC tail stage).
- Presents the group result on a valid/ready output.
- Upstream operand sequencing is out of scope; products arrive as a valid/ready stream.

---
 rtl/dot_accumulator_if.sv | 45 ++++
 rtl/dot_accumulator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dot_accumulator_if.sv
`default_nettype none
//==============================================================================
// Module      : dot_accumulator_if
// Description : Handshake bundle for the dot-product accumulator.
//               Product stream in (valid/ready + clear), group result out
//               (valid/ready), plus the debug term counter.
// Ports       : (interface signals)
//   in_valid   - prod is valid this cycle
//   in_ready   - accumulator accepts prod this cycle
//   prod       - 8-bit unsigned product
//   in_clear   - abort the current partial group
//   out_valid  - acc_out holds a completed group sum
//   out_ready  - downstream accepts acc_out
//   acc_out    - completed group sum (ACC_W bits)
//   ovf        - the group in acc_out overflowed ACC_W
//   cnt        - products accepted so far in the current group
// Modports    : master - producer/consumer side, slave - accumulator side
// Revision    : 1.0 - initial release
//==============================================================================
interface dot_accumulator_if #(
  parameter int ACC_W = 12
) ();

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       prod;
  logic             in_clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;
  logic [3:0]       cnt;

  modport master (
    output in_valid, prod, in_clear, out_ready,
    input  in_ready, out_valid, acc_out, ovf, cnt
  );

  modport slave (
    input  in_valid, prod, in_clear, out_ready,
    output in_ready, out_valid, acc_out, ovf, cnt
  );

endinterface : dot_accumulator_if
`default_nettype wire

// File: rtl/dot_accumulator.sv
`default_nettype none
//==============================================================================
// Module      : dot_accumulator
// Description : Accumulates groups of N_TERMS unsigned 8-bit products into an
//               ACC_W-bit sum and presents each group result on a
//               valid/ready output. A sticky flag records any carry out of
//               the accumulator during the group.
// Parameters  : N_TERMS - products per group (2..16)
//               ACC_W   - accumulator/result width (8..16)
// Build macro : ACC_SAT_EN - when defined the accumulator saturates at
//               2^ACC_W-1 on overflow instead of wrapping.
// Ports       : clk   - rising-edge clock
//               rst_n - synchronous active-low reset
//               bus   - dot_accumulator_if slave modport
// Revision    : 1.0 - initial release
//==============================================================================
module dot_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  dot_accumulator_if.slave   bus
);

  // State encoding
  localparam logic [0:0] c_ACCUM = 1'b0;
  localparam logic [0:0] c_HOLD  = 1'b1;

  // Counter value of the term that completes a group
  localparam logic [3:0] c_LAST = 4'(N_TERMS - 1);

  logic [0:0]       state_q,   state_d;
  logic [ACC_W-1:0] acc_q,     acc_d;
  logic [3:0]       cnt_q,     cnt_d;
  logic             sticky_q,  sticky_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             ovf_q,     ovf_d;

  logic             in_ready;
  logic             in_fire;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             ovf_now;
  logic [ACC_W-1:0] acc_next;

  // Ready is suppressed while reset is asserted so nothing is offered as
  // accepted during the reset cycle.
  assign in_ready = rst_n && (state_q == c_ACCUM);
  assign in_fire  = bus.in_valid && in_ready;

  // Sum computed one bit wider than the accumulator to expose the carry.
  assign prod_ext = {{(ACC_W-7){1'b0}}, bus.prod};
  assign sum_ext  = {1'b0, acc_q} + prod_ext;
  assign carry    = sum_ext[ACC_W];
  assign ovf_now  = sticky_q | carry;

`ifdef ACC_SAT_EN
  // Once the group has overflowed the accumulator pins at full scale.
  assign acc_next = ovf_now ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_next = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;

    case (state_q)
      c_ACCUM: begin
        if (bus.in_clear) begin
          // Clear wins over a concurrent transfer; that product is dropped.
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
        end else if (in_fire) begin
          if (cnt_q == c_LAST) begin
            acc_out_d = acc_next;
            ovf_d     = ovf_now;
            acc_d     = '0;
            cnt_d     = '0;
            sticky_d  = 1'b0;
            state_d   = c_HOLD;
          end else begin
            acc_d    = acc_next;
            cnt_d    = cnt_q + 4'd1;
            sticky_d = ovf_now;
          end
        end
      end
      c_HOLD: begin
        // Result held until taken; clear is ignored so it is never lost.
        if (bus.out_ready) begin
          state_d = c_ACCUM;
        end
      end
      default: begin
        state_d = c_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= c_ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == c_HOLD);
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.cnt       = cnt_q;

endmodule : dot_accumulator
`default_nettype wire
